// File: rtl/node_mac_sched.sv
// Serial neuron evaluator: ReLU(sum(a_i * w_i) + bias) using one shared multiplier and adder.
// Define NODE_MAC_PIPE_EN to register the product between the multiplier and the adder.
module node_mac_sched #(
  parameter int unsigned N_IN = 30,
  parameter int unsigned W_AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [31:0]     a_data,
  output logic [W_AW-1:0] w_addr,
  input  logic [31:0]     w_data,
  input  logic [31:0]     bias,
  output logic            n_valid,
  input  logic            n_ready,
  output logic [31:0]     n_data
);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StBias,
`ifdef NODE_MAC_PIPE_EN
    StDrain,
`endif
    StOut
  } state_e;

  // Single-precision multiply, round-to-nearest-even; denormals flush to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] prod;
    logic [24:0] man;
    logic        grd;
    logic        stk;
    int          exp;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {sgn, 8'hff, 23'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {sgn, 31'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      man = {1'b0, prod[47:24]};
      grd = prod[23];
      stk = |prod[22:0];
      exp = exp + 1;
    end else begin
      man = {1'b0, prod[46:23]};
      grd = prod[22];
      stk = |prod[21:0];
    end
    if (grd && (stk || man[0])) man = man + 25'd1;
    if (man[24]) begin
      man = man >> 1;
      exp = exp + 1;
    end
    if (exp >= 255) return {sgn, 8'hff, 23'd0};
    if (exp <= 0) return {sgn, 31'd0};
    return {sgn, exp[7:0], man[22:0]};
  endfunction

  // Single-precision add with guard/round/sticky bits, round-to-nearest-even.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] mask;
    logic [27:0] sum;
    logic [24:0] man;
    logic        grd;
    logic        stk;
    int          exp;
    int          sh;
    grd = 1'b0;
    stk = 1'b0;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    exp = int'(x[30:23]);
    sh  = exp - int'(y[30:23]);
    mx  = {1'b1, x[22:0], 3'b000};
    my  = {1'b1, y[22:0], 3'b000};
    if (sh > 26) begin
      my = 27'd1;
    end else if (sh > 0) begin
      mask = (27'd1 << sh) - 27'd1;
      stk  = |(my & mask);
      my   = (my >> sh) | {26'd0, stk};
    end
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        exp = exp + 1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, my};
      if (sum == 28'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          exp = exp - 1;
        end
      end
    end
    man = {1'b0, sum[26:3]};
    grd = sum[2];
    stk = |sum[1:0];
    if (grd && (stk || man[0])) man = man + 25'd1;
    if (man[24]) begin
      man = man >> 1;
      exp = exp + 1;
    end
    if (exp >= 255) return {x[31], 8'hff, 23'd0};
    if (exp <= 0) return {x[31], 31'd0};
    return {x[31], exp[7:0], man[22:0]};
  endfunction

  state_e          state_q, state_d;
  logic [31:0]     acc_q, acc_d;
  logic [W_AW-1:0] cnt_q, cnt_d;
  logic [31:0]     n_data_q, n_data_d;
  logic [31:0]     prod;
  logic [31:0]     add_b;
  logic [31:0]     add_res;
  logic            beat;
  logic            last_beat;
`ifdef NODE_MAC_PIPE_EN
  logic [31:0]     prod_q, prod_d;
  logic            prod_v_q, prod_v_d;
`endif

  assign beat      = (state_q == StAccum) && a_valid;
  assign last_beat = beat && (cnt_q == W_AW'(N_IN - 1));
  assign prod      = fp_mul(a_data, w_data);
  assign add_res   = fp_add(acc_q, add_b);

  assign busy    = (state_q != StIdle);
  assign a_ready = (state_q == StAccum);
  assign n_valid = (state_q == StOut);
  assign w_addr  = a_ready ? cnt_q : '0;
  assign n_data  = n_data_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    n_data_d = n_data_q;
`ifdef NODE_MAC_PIPE_EN
    add_b    = prod_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
`else
    add_b    = prod;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
`ifdef NODE_MAC_PIPE_EN
        // Product of the previous beat is folded in while this beat multiplies.
        if (prod_v_q) acc_d = add_res;
        if (beat) begin
          prod_d   = prod;
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + W_AW'(1);
        end
        if (last_beat) begin
          cnt_d   = '0;
          state_d = StDrain;
        end
`else
        if (beat) begin
          acc_d = add_res;
          cnt_d = cnt_q + W_AW'(1);
        end
        if (last_beat) begin
          cnt_d   = '0;
          state_d = StBias;
        end
`endif
      end
`ifdef NODE_MAC_PIPE_EN
      StDrain: begin
        if (prod_v_q) acc_d = add_res;
        state_d = StBias;
      end
`endif
      StBias: begin
        add_b    = bias;
        acc_d    = add_res;
        // ReLU: any set sign bit, including -0.0, yields +0.
        n_data_d = add_res[31] ? 32'd0 : add_res;
        state_d  = StOut;
      end
      StOut: begin
        if (n_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      n_data_q <= '0;
`ifdef NODE_MAC_PIPE_EN
      prod_q   <= '0;
      prod_v_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      n_data_q <= n_data_d;
`ifdef NODE_MAC_PIPE_EN
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_node_mac_sched.sv
// Self-checking bench for node_mac_sched; values are multiples of 0.25 so the reference
// model is exact integer arithmetic in quarter units.
module tb_node_mac_sched;
  localparam int unsigned NIn = 4;
  localparam int unsigned WAw = 2;
`ifdef NODE_MAC_PIPE_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           a_valid;
  logic           a_ready;
  logic [31:0]    a_data;
  logic [WAw-1:0] w_addr;
  logic [31:0]    w_data;
  logic [31:0]    bias;
  logic           n_valid;
  logic           n_ready;
  logic [31:0]    n_data;

  logic [31:0] w_rom [NIn];
  int          ah [NIn];  // activations in halves
  int          wh [NIn];  // weights in halves
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  assign w_data = w_rom[w_addr];

  node_mac_sched #(.N_IN(NIn), .W_AW(WAw)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .bias    (bias),
    .n_valid (n_valid),
    .n_ready (n_ready),
    .n_data  (n_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact single-precision encoding of q/4.
  function automatic logic [31:0] q2f(input int q);
    int          m;
    int          p;
    logic [31:0] mm;
    if (q == 0) return 32'd0;
    m = (q < 0) ? -q : q;
    p = 0;
    for (int i = 0; i < 31; i++) if (m[i]) p = i;
    mm = 32'(m) << (23 - p);
    return {(q < 0) ? 1'b1 : 1'b0, 8'(p + 125), mm[22:0]};
  endfunction

  // mode: 0 continuous a_valid, 1 fixed gap pattern, 2 random gaps.
  task automatic eval(input int bq, input int mode, input int stall, input bit poke);
    int          expq;
    int          i;
    int          cyc;
    int          pidx;
    int          guard;
    logic [31:0] expv;
    logic [6:0]  pat;
    pat  = 7'b1101001;
    expq = bq;
    for (int k = 0; k < NIn; k++) expq += ah[k] * wh[k];
    expv = (expq > 0) ? q2f(expq) : 32'd0;
    for (int k = 0; k < NIn; k++) w_rom[k] = q2f(wh[k] * 2);
    bias    = q2f(bq);
    n_ready = (stall == 0);
    start   = 1'b1;
    tick;
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    i     = 0;
    pidx  = 0;
    guard = 0;
    while (i < int'(NIn) && guard < 100) begin
      case (mode)
        0:       a_valid = 1'b1;
        1:       a_valid = (pidx < 7) ? pat[pidx] : 1'b1;
        default: a_valid = ($urandom_range(0, 2) != 0);
      endcase
      a_data = q2f(ah[i] * 2);
      start  = poke && ($urandom_range(0, 3) == 0);
      chk("a_ready", 32'(a_ready), 32'd1);
      chk("w_addr", 32'(w_addr), 32'(i));
      tick;
      cyc++;
      pidx++;
      guard++;
      if (a_valid) i++;
    end
    chk("beats_done", 32'(i), NIn);
    a_valid = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < Lat - 1; k++) begin
      chk("n_valid_early", 32'(n_valid), 32'd0);
      chk("busy_post", 32'(busy), 32'd1);
      tick;
      cyc++;
    end
    chk("n_valid", 32'(n_valid), 32'd1);
    chk("n_data", n_data, expv);
    for (int s = 0; s < stall; s++) begin
      start = poke;
      tick;
      chk("stall_n_valid", 32'(n_valid), 32'd1);
      chk("stall_n_data", n_data, expv);
    end
    n_ready = 1'b1;
    start   = poke;
    tick;
    cyc++;
    start = 1'b0;
    chk("done_n_valid", 32'(n_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    if (mode == 0 && stall == 0 && !poke) chk("idle_to_idle", 32'(cyc), NIn + Lat + 1);
    tick;
    chk("no_requeue_busy", 32'(busy), 32'd0);
    chk("no_requeue_n_valid", 32'(n_valid), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    a_valid = 1'b0;
    a_data  = 32'd0;
    n_ready = 1'b1;
    bias    = 32'd0;
    for (int k = 0; k < NIn; k++) w_rom[k] = 32'd0;
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_n_valid", 32'(n_valid), 32'd0);
    chk("rst_n_data", n_data, 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    rst_n = 1'b1;
    tick;

    // 1+2+3+4 + 0.5 = 10.5
    ah = '{2, 4, 6, 8};
    wh = '{2, 2, 2, 2};
    eval(2, 0, 0, 1'b0);
    chk("basic_value", n_data, 32'h41280000);

    // -10 + 0.5 clamps to zero
    ah = '{-2, -4, -6, -8};
    eval(2, 0, 0, 1'b0);

    ah = '{2, 4, 6, 8};
    eval(2, 1, 5, 1'b0);
    eval(2, 0, 3, 1'b1);

    // Reset mid-evaluation after two beats
    start = 1'b1;
    tick;
    start   = 1'b0;
    a_valid = 1'b1;
    a_data  = q2f(4);
    tick;
    a_data = q2f(8);
    tick;
    a_valid = 1'b0;
    rst_n   = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    chk("midrst_n_valid", 32'(n_valid), 32'd0);
    chk("midrst_n_data", n_data, 32'd0);
    chk("midrst_w_addr", 32'(w_addr), 32'd0);
    tick;
    chk("midrst_still_idle", 32'(n_valid), 32'd0);
    eval(2, 0, 0, 1'b0);
    chk("post_rst_value", n_data, 32'h41280000);

    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < NIn; k++) begin
        ah[k] = int'($urandom_range(0, 32)) - 16;
        wh[k] = int'($urandom_range(0, 32)) - 16;
      end
      eval(int'($urandom_range(0, 64)) - 32, 2, int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/node_mac_sched.md
Name: node_mac_sched

Overview:
- Serial neuron evaluator for the layer datapath. One shared float_mult and one shared float_adder replace the fully parallel multiplier and adder tree.
- Computes ReLU(sum of A_i*W_i over i=0..N_IN-1, plus bias), consuming one activation per beat.
- Fetches weights from an external combinational weight ROM.
- Sits between the activation stream from the previous layer and the neuron output register bank.

Parameters:
- N_IN, 30, number of inputs per neuron (>=2).
- W_AW, 5, weight ROM address width; 2^W_AW >= N_IN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin one neuron evaluation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- a_valid  in  1  activation beat valid.
- a_ready  out  1  activation beat accepted when a_valid&a_ready.
- a_data  in  32  IEEE-754 single activation.
- w_addr  out  W_AW  weight ROM address; equals beat index cnt.
- w_data  in  32  weight for w_addr, valid in the same cycle.
- bias  in  32  IEEE-754 bias; must be stable from start until n_valid.
- n_valid  out  1  result valid.
- n_ready  in  1  result consumer ready.
- n_data  out  32  ReLU'd neuron output.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - acc=0, cnt=0.
  - busy=0, a_ready=0, n_valid=0, n_data=0, w_addr=0.
  - Reset overrides everything, including mid-evaluation. A partial sum is discarded and no n_valid is produced for it.
- FSM states: IDLE, ACCUM, BIAS, OUT; plus DRAIN only when MAC_PIPE_EN is defined.
- IDLE:
  - a_ready=0, w_addr=0.
  - start=1 → acc<=32'h00000000, cnt<=0, go to ACCUM.
- ACCUM:
  - a_ready=1, w_addr=cnt.
  - On each beat: acc <= float_adder(acc, float_mult(a_data, w_data)) and cnt<=cnt+1.
  - No beat → acc and cnt hold. Gaps in a_valid are legal.
  - Beat with cnt==N_IN-1 → go to BIAS (or DRAIN) and set cnt<=0.
- BIAS:
  - a_ready=0.
  - acc <= float_adder(acc, bias) in one cycle, then go to OUT.
- OUT:
  - n_valid=1.
  - n_data is registered on entry: 32'd0 if acc[31]==1 (including -0.0), otherwise acc.
  - n_data and n_valid hold while n_ready=0.
  - n_valid&n_ready → n_valid<=0, go to IDLE.
- start while busy is ignored; it is not queued. A start in the same cycle as the OUT handshake is also ignored; the next evaluation needs start in IDLE.
- Latency:
  - Last beat accepted at cycle T → n_valid=1 at T+2.
  - Minimum IDLE-to-IDLE time is N_IN+3 cycles with continuous a_valid and n_ready=1.
- Arithmetic:
  - Accumulation order is strictly by input index.
  - Rounding and denormal behaviour are inherited from float_mult and float_adder; no extra normalisation.
- w_addr never exceeds N_IN-1.

Optional Feature:
- Macro: NODE_MAC_PIPE_EN.
- When defined:
  - A pipeline register (prod_q, prod_v) sits between float_mult and float_adder.
  - ACCUM adds prod_q when prod_v is set, so an accepted beat's product is added one cycle later.
  - After the last beat the FSM goes to DRAIN for one cycle to add the final product, then to BIAS.
  - Latency becomes last beat at T → n_valid at T+3.
  - prod_v is cleared on reset and in IDLE.
- When undefined:
  - The multiply-add path is combinational within one cycle, as described above.
  - DRAIN does not exist.
- Results must be bit-identical between the two builds.

Test Plan:
- N_IN=4; w=1.0 (3F800000) at all addresses; a=1.0,2.0,3.0,4.0; bias=0.5; continuous valid → n_data=41280000 (10.5), n_valid at T+2, busy low one cycle after handshake.
- Same weights; a=-1.0,-2.0,-3.0,-4.0; bias=0.5 → acc=-9.5 (C1180000), n_data=00000000, n_valid asserted.
- a_valid pattern 1,0,0,1,0,1,1; n_ready low for 5 cycles in OUT → result still 41280000; n_data/n_valid stable while stalled; w_addr sequence 0,1,2,3 advances only on beats.
- start pulsed during ACCUM and during OUT → ignored; exactly one n_valid per accepted start.
- rst_n=0 for one cycle after 2 beats → IDLE, all outputs 0. A new start and 4 beats then give a correct 41280000 with no residue from the prior partial sum.
- Repeat the first scenario with NODE_MAC_PIPE_EN defined → same 41280000, n_valid at T+3.
